// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED sequence controller.
//   SEQ_LEN / IDX_W : length of the pattern sequence and width of its index
//   PATTERN         : 6 x 4-bit LED patterns; entry i sits at bits [4*i +: 4]
//   state_t         : controller FSM states
//   pattern_of()    : pattern lookup; out-of-range indices map to entry 0
package led_seq_pkg;

  localparam int SEQ_LEN = 6;
  localparam int IDX_W   = 3;

  // idx:                         5        4        3        2        1        0
  localparam logic [SEQ_LEN*4-1:0] PATTERN = {4'b0111, 4'b1110, 4'b0000, 4'b0101, 4'b1010, 4'b1111};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  function automatic logic [3:0] pattern_of(input logic [IDX_W-1:0] idx);
    if (idx < IDX_W'(SEQ_LEN)) pattern_of = PATTERN[4*idx +: 4];
    else                       pattern_of = PATTERN[3:0];
  endfunction

endpackage

// File: rtl/led_seq_ctrl_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, debounce counter and a
// falling-edge press pulse.
//   clk, rst : clock, synchronous active-high reset
//   btn_n    : raw active-low button, asynchronous to clk
//   press    : registered one-cycle pulse when the debounced level goes 1->0
// The debounced level only flips after the synchronised input has disagreed
// with it for DEB_CYCLES consecutive cycles; any agreeing cycle restarts the
// count. press is a fire-and-forget pulse with no back-pressure.
module btn_debounce #(
  parameter int DEB_CYCLES = 1000000,
  parameter int CNT_W      = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;
  logic             commit;

  // Last disagreeing cycle of the run: the level flips on this edge.
  assign commit = (sync2 != level) && (cnt == CNT_W'(DEB_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
      press <= commit && !sync2;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (commit) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// Run/hold/step controller for the 4-bit LED pattern sequence.
//   clk, rst   : clock, synchronous active-high reset
//   run_en     : 1 = auto-run from the prescaler tick
//   dir        : 0 = forward (idx+1), 1 = reverse (idx-1), sampled on advance
//   speed      : auto-run period = TICK_DIV << speed cycles
//   step_btn_n : raw active-low step button
//   LEDR       : registered pattern, always PATTERN[seq_idx]
//   seq_idx    : registered index 0..5
//   running    : 1 while the FSM is in RUN
//   wrap       : one-cycle pulse on the edge where the index wraps
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int TICK_DIV   = 25000000,
  parameter int DEB_CYCLES = 1000000,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_en,
  input  logic             dir,
  input  logic [1:0]       speed,
  input  logic             step_btn_n,
  output logic [3:0]       LEDR,
  output logic [IDX_W-1:0] seq_idx,
  output logic             running,
  output logic             wrap
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEQ_LEN - 1);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] presc;
  logic [CNT_W-1:0] period_m1;
  logic             press;
  logic             tick;
  logic             advance;
  logic [IDX_W-1:0] idx_next;
  logic             wrap_next;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .CNT_W      (CNT_W)
  ) u_step_btn (
    .clk   (clk),
    .rst   (rst),
    .btn_n (step_btn_n),
    .press (press)
  );

  // >= rather than == so lowering speed mid-count fires at once instead of
  // running the counter past the new period.
  assign period_m1 = (CNT_W'(TICK_DIV) << speed) - CNT_W'(1);
  assign tick      = (state == RUN) && (presc >= period_m1);

  always_ff @(posedge clk) begin
    if (rst || (state != RUN) || tick) presc <= '0;
    else                               presc <= presc + CNT_W'(1);
  end

  always_comb begin
    next_state = state;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (run_en) next_state = RUN;
        else if (press) begin
          advance    = 1'b1;
          next_state = HOLD;
        end
      end
      RUN: begin
        // A tick on the same cycle run_en drops is still honoured.
        advance = tick;
        if (!run_en) next_state = HOLD;
      end
      HOLD: begin
        if (run_en)     next_state = RUN;
        else if (press) advance    = 1'b1;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    idx_next  = seq_idx;
    wrap_next = 1'b0;
    if (seq_idx > LAST_IDX) begin
      idx_next = '0;
    end else if (advance) begin
      if (!dir) begin
        if (seq_idx == LAST_IDX) begin
          idx_next  = '0;
          wrap_next = 1'b1;
        end else begin
          idx_next = seq_idx + IDX_W'(1);
        end
      end else begin
        if (seq_idx == '0) begin
          idx_next  = LAST_IDX;
          wrap_next = 1'b1;
        end else begin
          idx_next = seq_idx - IDX_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      seq_idx <= '0;
      LEDR    <= pattern_of('0);
      running <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      state   <= next_state;
      seq_idx <= idx_next;
      LEDR    <= pattern_of(idx_next);
      running <= (next_state == RUN);
      wrap    <= wrap_next;
    end
  end

endmodule
